// File: rtl/sdram_arb_pkg.sv
// Shared encodings and default sizes for the SDRAM request arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W_DEF       = 22;
    localparam int LEN_W_DEF        = 9;
    localparam int REF_INTERVAL_DEF = 780;
    localparam int REF_DEBT_MAX_DEF = 7;
    localparam int WR_STARVE_DEF    = 4;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_REFRESH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh tick generator with a saturating owed-refresh counter
// and a sticky overrun flag.
module sdram_ref_timer
    import sdram_arb_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int REF_DEBT_MAX = REF_DEBT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic init_done,
    input  logic ref_accept,
    output logic ref_pending,
    output logic ref_overrun
);
    localparam int CNT_W  = $clog2(REF_INTERVAL);
    localparam int DEBT_W = $clog2(REF_DEBT_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REF_INTERVAL - 1);
    localparam logic [DEBT_W-1:0] DEBT_SAT = DEBT_W'(REF_DEBT_MAX);

    logic [CNT_W-1:0]  cnt_r;
    logic [DEBT_W-1:0] debt_r;
    logic              overrun_r;
    logic              tick_s;

    assign tick_s      = init_done && (cnt_r == CNT_LAST);
    assign ref_pending = (debt_r != DEBT_W'(0));
    assign ref_overrun = overrun_r;

    // Interval counter, parked at zero until the SDRAM is initialised.
    always_ff @(posedge clk) begin
        if (rst || !init_done || tick_s) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Debt bookkeeping: a tick and an accepted refresh in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            debt_r    <= DEBT_W'(0);
            overrun_r <= 1'b0;
        end else begin
            case ({tick_s, ref_accept})
                2'b10: begin
                    if (debt_r == DEBT_SAT) begin
                        overrun_r <= 1'b1;
                    end else begin
                        debt_r <= debt_r + DEBT_W'(1);
                    end
                end
                2'b01: begin
                    if (debt_r != DEBT_W'(0)) begin
                        debt_r <= debt_r - DEBT_W'(1);
                    end
                end
                default: begin
                    debt_r <= debt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates refresh, display reads and user writes onto the single SDRAM
// command sequencer, one non-preemptive command at a time.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int LEN_W        = LEN_W_DEF,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int REF_DEBT_MAX = REF_DEBT_MAX_DEF,
    parameter int WR_STARVE    = WR_STARVE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_ack,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_ack,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              busy,
    output logic              ref_overrun
);
    localparam int STV_W = $clog2(WR_STARVE + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(WR_STARVE);

    arb_state_e        state_r, next_state_s;
    logic [1:0]        cmd_op_r, grant_op_s;
    logic [ADDR_W-1:0] cmd_addr_r, grant_addr_s;
    logic [LEN_W-1:0]  cmd_len_r, grant_len_s;
    logic              cmd_valid_r, busy_r;
    logic              zero_rd_r, zero_wr_r;
    logic [STV_W-1:0]  starve_r;
    logic              grant_s, zero_sel_s, issue_sel_s, accept_s;
    logic              rd_ack_s, wr_ack_s;
    logic              ref_pending_s, ref_accept_s;

    assign accept_s     = (state_r == ST_ISSUE) && cmd_ready;
    assign ref_accept_s = accept_s && (cmd_op_r == OP_REFRESH);

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_DEBT_MAX (REF_DEBT_MAX)
    ) u_ref_timer (
        .clk         (clk),
        .rst         (rst),
        .init_done   (init_done),
        .ref_accept  (ref_accept_s),
        .ref_pending (ref_pending_s),
        .ref_overrun (ref_overrun)
    );

    // Winner selection in IDLE; held off while a zero-length ack is in flight
    // so the still-asserted request is not granted twice.
    always_comb begin
        grant_s      = 1'b0;
        grant_op_s   = OP_NOP;
        grant_addr_s = '0;
        grant_len_s  = '0;
        if ((state_r == ST_IDLE) && init_done && !zero_rd_r && !zero_wr_r) begin
            if (ref_pending_s) begin
                grant_s    = 1'b1;
                grant_op_s = OP_REFRESH;
            end else if (wr_req && (starve_r == STV_MAX)) begin
                grant_s      = 1'b1;
                grant_op_s   = OP_WRITE;
                grant_addr_s = wr_addr;
                grant_len_s  = wr_len;
            end else if (rd_req) begin
                grant_s      = 1'b1;
                grant_op_s   = OP_READ;
                grant_addr_s = rd_addr;
                grant_len_s  = rd_len;
            end else if (wr_req) begin
                grant_s      = 1'b1;
                grant_op_s   = OP_WRITE;
                grant_addr_s = wr_addr;
                grant_len_s  = wr_len;
            end else begin
                grant_s = 1'b0;
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    assign zero_sel_s  = grant_s && (grant_op_s != OP_REFRESH) && (grant_len_s == LEN_W'(0));
    assign issue_sel_s = grant_s && !zero_sel_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  next_state_s = issue_sel_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: next_state_s = cmd_ready   ? ST_WAIT  : ST_ISSUE;
            ST_WAIT:  next_state_s = cmd_done    ? ST_IDLE  : ST_WAIT;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: acks fire in the accept cycle or one cycle after a zero-length pick.
    always_comb begin
        rd_ack_s = zero_rd_r || (accept_s && (cmd_op_r == OP_READ));
        wr_ack_s = zero_wr_r || (accept_s && (cmd_op_r == OP_WRITE));
    end

    // Registered command bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_op_r    <= OP_NOP;
            cmd_addr_r  <= '0;
            cmd_len_r   <= '0;
            zero_rd_r   <= 1'b0;
            zero_wr_r   <= 1'b0;
        end else begin
            cmd_valid_r <= (next_state_s == ST_ISSUE);
            busy_r      <= (next_state_s != ST_IDLE);
            zero_rd_r   <= zero_sel_s && (grant_op_s == OP_READ);
            zero_wr_r   <= zero_sel_s && (grant_op_s == OP_WRITE);
            if (issue_sel_s) begin
                cmd_op_r   <= grant_op_s;
                cmd_addr_r <= grant_addr_s;
                cmd_len_r  <= grant_len_s;
            end
        end
    end

    // Count reads granted past a waiting write so the write cannot starve.
    always_ff @(posedge clk) begin
        if (rst || wr_ack_s || ((state_r == ST_IDLE) && !wr_req)) begin
            starve_r <= STV_W'(0);
        end else if (rd_ack_s && wr_req && (starve_r != STV_MAX)) begin
            starve_r <= starve_r + STV_W'(1);
        end
    end

    assign rd_ack    = rd_ack_s;
    assign wr_ack    = wr_ack_s;
    assign cmd_valid = cmd_valid_r;
    assign cmd_op    = cmd_op_r;
    assign cmd_addr  = cmd_addr_r;
    assign cmd_len   = cmd_len_r;
    assign busy      = busy_r;

endmodule
